// File: rtl/fcs_pkg.sv
// Shared types and sizing helpers for the fanout capture serializer.
// Beat count and counter widths are derived here so the interface and the top agree.
package fcs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int nbeats(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // A beat index needs at least one bit even for a single-beat word.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fanout_capture_serializer_if.sv
// Capture-side and stream-side handshake bundle for the fanout capture serializer.
// The slave modport is the serializer; the master modport is the upstream/consumer side.
interface fanout_capture_serializer_if
  import fcs_pkg::*;
#(
  parameter int WIDTH = 150,
  parameter int CHUNK = 8
) ();

  localparam int NBEATS = nbeats(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NBEATS);
  localparam int CNT_W  = cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CHUNK-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             pc_valid;
  logic [CNT_W-1:0] pc_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, pc_valid, pc_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, pc_valid, pc_count
  );

endinterface

// File: rtl/chunk_popcount.sv
// Combinational count of set bits in one output beat.
module chunk_popcount #(
  parameter int CHUNK = 8,
  parameter int OUT_W = 8
) (
  input  logic [CHUNK-1:0] i_data,
  output logic [OUT_W-1:0] o_count
);

  // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + OUT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/fanout_capture_serializer.sv
// Captures a WIDTH-bit word with valid/ready, streams it CHUNK bits per beat LSB first,
// and reports the word's popcount one cycle after the final beat.
module fanout_capture_serializer
  import fcs_pkg::*;
#(
  parameter int WIDTH = 150,
  parameter int CHUNK = 8
) (
  input logic                          clk1,
  input logic                          rst_n,
  fanout_capture_serializer_if.slave   bus
);

  localparam int NBEATS = nbeats(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NBEATS);
  localparam int CNT_W  = cnt_w(WIDTH);
  localparam int PAD_W  = NBEATS * CHUNK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PAD_W-1:0] r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_pc_count;
  logic             r_pc_valid;

  logic             w_last;
  logic             w_fire_out;
  logic             w_fire_in;
  logic             w_done;
  logic [CNT_W-1:0] w_beat_cnt;

  chunk_popcount #(
    .CHUNK (CHUNK),
    .OUT_W (CNT_W)
  ) u_chunk_popcount (
    .i_data  (r_shift[CHUNK-1:0]),
    .o_count (w_beat_cnt)
  );

  assign w_last     = (r_state == SEND) && (r_idx == LAST_IDX);
  assign w_fire_out = (r_state == SEND) && bus.out_ready;
  assign w_done     = w_fire_out && w_last;
  // A new word may land in the same cycle the last beat leaves, giving gap-free streaming.
  assign w_fire_in  = bus.in_valid && ((r_state == IDLE) || w_done);

  assign bus.in_ready  = (r_state == IDLE) || w_done;
  assign bus.out_valid = (r_state == SEND);
  assign bus.out_data  = r_shift[CHUNK-1:0];
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = w_last;
  assign bus.pc_valid  = r_pc_valid;
  assign bus.pc_count  = r_pc_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fire_in) w_state_nxt = SEND;
      SEND:    if (w_done && !w_fire_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' and an asynchronous active-low clear of every register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_pc_count <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc_valid <= w_done;
      if (w_done) begin
        r_pc_count <= r_acc + w_beat_cnt;
      end
      // Capture wins over advance: the last beat's count has already gone to r_pc_count.
      if (w_fire_in) begin
        r_shift <= PAD_W'(bus.in_data);
        r_idx   <= '0;
        r_acc   <= '0;
      end else if (w_fire_out) begin
        r_shift <= r_shift >> CHUNK;
        r_idx   <= r_idx + IDX_W'(1);
        r_acc   <= r_acc + w_beat_cnt;
      end
    end
  end

endmodule
